// File: rtl/tiny_calc_if.sv
// Operator-facing bus of the tiny calculator sequencer.
// Carries switches and keys into the sequencer, and seven-segment digits and
// state LEDs back out.
//   SW        : operand value from the slide switches, asynchronous to clk
//   KEY_ENTER : active-low confirm key
//   KEY_CLEAR : active-low abort key
//   HEX0..3   : active-low segment patterns (A, B, sum low, sum high)
//   LEDR      : one-hot state indication
interface tiny_calc_if;
  logic [3:0] SW;
  logic       KEY_ENTER;
  logic       KEY_CLEAR;
  logic [6:0] HEX0;
  logic [6:0] HEX1;
  logic [6:0] HEX2;
  logic [6:0] HEX3;
  logic [3:0] LEDR;

  modport master (
    output SW, KEY_ENTER, KEY_CLEAR,
    input  HEX0, HEX1, HEX2, HEX3, LEDR
  );

  modport slave (
    input  SW, KEY_ENTER, KEY_CLEAR,
    output HEX0, HEX1, HEX2, HEX3, LEDR
  );
endinterface

// File: rtl/tiny_calc_sequencer.sv
// Front-end controller for the 4-bit adder: collects operand A and B from the
// switches on debounced ENTER presses, adds them, and shows A, B and the 5-bit
// sum on four active-low seven-segment digits. CLEAR restarts entry.
//   clk  : system clock, all state on rising edge
//   rst  : asynchronous active-high reset
//   bus  : operator bus (switches, keys in; HEX digits, LEDR out)
module tiny_calc_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned BLINK_CYCLES    = 12500000
) (
  input  logic       clk,
  input  logic       rst,
  tiny_calc_if.slave bus
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    S_ENTER_A = 2'd0,
    S_ENTER_B = 2'd1,
    S_ADD     = 2'd2,
    S_RESULT  = 2'd3
  } state_e;

  // Active-low segment pattern, bit6 = g .. bit0 = a
  function automatic logic [6:0] seg7(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;  4'h1: s = 7'h79;  4'h2: s = 7'h24;  4'h3: s = 7'h30;
      4'h4: s = 7'h19;  4'h5: s = 7'h12;  4'h6: s = 7'h02;  4'h7: s = 7'h78;
      4'h8: s = 7'h00;  4'h9: s = 7'h10;  4'hA: s = 7'h08;  4'hB: s = 7'h03;
      4'hC: s = 7'h46;  4'hD: s = 7'h21;  4'hE: s = 7'h06;  4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  state_e            state_q, state_d;
  logic [3:0]        sw_s1_q, sw_s2_q;
  logic              en_s1_q, en_s2_q, en_prev_q;
  logic              cl_s1_q, cl_s2_q, cl_prev_q;
  logic [DB_W-1:0]   db_q, db_d;
  logic [BL_W-1:0]   blink_q, blink_d;
  logic              phase_q, phase_d;
  logic [3:0]        a_q, a_d, b_q, b_d;
  logic [4:0]        sum_q, sum_d;
  logic [6:0]        hex0_q, hex1_q, hex2_q, hex3_q;
  logic [6:0]        hex0_d, hex1_d, hex2_d, hex3_d;
  logic              db_idle_c, en_press_c, cl_press_c, clear_c;

  // Two-flop synchronizers plus one delayed copy of each key for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q   <= '0;
      sw_s2_q   <= '0;
      en_s1_q   <= 1'b1;
      en_s2_q   <= 1'b1;
      en_prev_q <= 1'b1;
      cl_s1_q   <= 1'b1;
      cl_s2_q   <= 1'b1;
      cl_prev_q <= 1'b1;
    end else begin
      sw_s1_q   <= bus.SW;
      sw_s2_q   <= sw_s1_q;
      en_s1_q   <= bus.KEY_ENTER;
      en_s2_q   <= en_s1_q;
      en_prev_q <= en_s2_q;
      cl_s1_q   <= bus.KEY_CLEAR;
      cl_s2_q   <= cl_s1_q;
      cl_prev_q <= cl_s2_q;
    end
  end

  // Press pulses; both keys share one lockout counter
  always_comb begin
    db_idle_c  = (db_q == '0);
    en_press_c = en_prev_q & ~en_s2_q & db_idle_c;
    cl_press_c = cl_prev_q & ~cl_s2_q & db_idle_c;
    clear_c    = cl_press_c && (state_q != S_ADD);
    db_d       = db_q;
    if (en_press_c || cl_press_c) begin
      db_d = DB_W'(DEBOUNCE_CYCLES - 1);
    end else if (!db_idle_c) begin
      db_d = db_q - DB_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_ENTER_A;
    else     state_q <= state_d;
  end

  // FSM next state; CLEAR beats ENTER, ADD ignores keys
  always_comb begin
    state_d = state_q;
    if (clear_c) begin
      state_d = S_ENTER_A;
    end else begin
      unique case (state_q)
        S_ENTER_A: if (en_press_c) state_d = S_ENTER_B;
        S_ENTER_B: if (en_press_c) state_d = S_ADD;
        S_ADD:                     state_d = S_RESULT;
        S_RESULT:  if (en_press_c) state_d = S_ENTER_A;
      endcase
    end
  end

  // FSM outputs: operand/sum capture, blink timing and next digit contents
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    sum_d  = sum_q;
    hex0_d = hex0_q;
    hex1_d = hex1_q;
    hex2_d = hex2_q;
    hex3_d = hex3_q;

    if (clear_c) begin
      a_d   = '0;
      b_d   = '0;
      sum_d = '0;
    end else begin
      unique case (state_q)
        S_ENTER_A: if (en_press_c) a_d = sw_s2_q;
        S_ENTER_B: if (en_press_c) b_d = sw_s2_q;
        S_ADD:     sum_d = {1'b0, a_q} + {1'b0, b_q};
        S_RESULT:  ;
      endcase
    end

    // Blink restarts visible on every state change
    if (state_d != state_q) begin
      blink_d = '0;
      phase_d = 1'b0;
    end else if (blink_q == BL_W'(BLINK_CYCLES - 1)) begin
      blink_d = '0;
      phase_d = ~phase_q;
    end else begin
      blink_d = blink_q + BL_W'(1);
      phase_d = phase_q;
    end

    unique case (state_q)
      S_ENTER_A: begin
        hex3_d = SEG_BLANK;
        hex2_d = SEG_BLANK;
        hex1_d = SEG_BLANK;
        hex0_d = phase_q ? SEG_BLANK : seg7(sw_s2_q);
      end
      S_ENTER_B: begin
        hex3_d = SEG_BLANK;
        hex2_d = SEG_BLANK;
        hex1_d = phase_q ? SEG_BLANK : seg7(sw_s2_q);
        hex0_d = seg7(a_q);
      end
      S_ADD: ;
      S_RESULT: begin
        hex3_d = seg7({3'b000, sum_q[4]});
        hex2_d = seg7(sum_q[3:0]);
        hex1_d = seg7(b_q);
        hex0_d = seg7(a_q);
      end
    endcase
  end

  // Datapath, counters and registered digits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q    <= '0;
      blink_q <= '0;
      phase_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      hex0_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
      hex3_q  <= SEG_BLANK;
    end else begin
      db_q    <= db_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      hex0_q  <= hex0_d;
      hex1_q  <= hex1_d;
      hex2_q  <= hex2_d;
      hex3_q  <= hex3_d;
    end
  end

  // One-hot state LEDs straight from the state register
  always_comb begin
    bus.LEDR = 4'b0000;
    unique case (state_q)
      S_ENTER_A: bus.LEDR = 4'b0001;
      S_ENTER_B: bus.LEDR = 4'b0010;
      S_ADD:     bus.LEDR = 4'b0100;
      S_RESULT:  bus.LEDR = 4'b1000;
    endcase
  end

  assign bus.HEX0 = hex0_q;
  assign bus.HEX1 = hex1_q;
  assign bus.HEX2 = hex2_q;
  assign bus.HEX3 = hex3_q;

endmodule

// File: doc/tiny_calc_sequencer.md
Name: tiny_calc_sequencer

Overview:
Sequential front-end controller for the 4-bit tiny adder datapath on the board. The operator enters operand A and then operand B on SW[3:0], confirming each with a debounced ENTER key. The block then computes the 5-bit sum and drives it on the four active-low seven-segment digits in the fixed result layout: HEX3..HEX0 = sum-high, sum-low, B, A. A CLEAR key aborts and restarts the sequence.

Parameters:
DEBOUNCE_CYCLES, 500000, clk cycles a key is ignored after an accepted press (10 ms at 50 MHz)
BLINK_CYCLES, 12500000, clk cycles per blink half-period of the digit being entered

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
SW  input  4  operand value from the slide switches, asynchronous to clk
KEY_ENTER  input  1  active-low pushbutton, confirm operand / restart after result
KEY_CLEAR  input  1  active-low pushbutton, abort to operand-A entry
HEX0  output  7  active-low segments, digit for operand A
HEX1  output  7  active-low segments, digit for operand B
HEX2  output  7  active-low segments, sum[3:0]
HEX3  output  7  active-low segments, sum[4]
LEDR  output  4  one-hot state: bit0 ENTER_A, bit1 ENTER_B, bit2 ADD, bit3 RESULT

Behaviour:
- Reset (async, active-high): state ENTER_A; A, B = 0; sum = 0; debounce and blink counters = 0; blink phase = visible; synchronizers loaded with 1 (keys released), SW sync = 0; HEX0..HEX3 = 7'h7F (blank); LEDR = 4'b0001.
- Seg encoding, bit6 = g .. bit0 = a, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
  - blank=7F
- SW, KEY_ENTER and KEY_CLEAR each pass through a 2-flop synchronizer.
- Press pulse: a synced key going 1->0 while the debounce counter is 0. An accepted press loads the debounce counter with DEBOUNCE_CYCLES-1. The counter decrements to 0, and key edges are ignored while it is nonzero. Both keys share one counter.
- ENTER and CLEAR pulses in the same cycle: CLEAR wins.
- CLEAR pulse in any state: next state ENTER_A; A, B, sum = 0.
- State transitions:
  - ENTER_A + ENTER pulse: A <= synced SW, go to ENTER_B.
  - ENTER_B + ENTER pulse: B <= synced SW, go to ADD.
  - ADD (exactly 1 cycle, keys ignored): sum <= {1'b0,A} + {1'b0,B}, go to RESULT.
  - RESULT + ENTER pulse: go to ENTER_A. A and B are kept internally but not shown.
- Blink: counter counts 0..BLINK_CYCLES-1, then wraps and toggles phase. Counter and phase are forced to 0 / visible on every state change.
- HEX outputs are registered, one cycle after state/data. Content per state:
  - ENTER_A: HEX3..HEX1 blank; HEX0 = seg(SW) if phase visible, else blank.
  - ENTER_B: HEX3, HEX2 blank; HEX1 = seg(SW) blinking; HEX0 = seg(A) steady.
  - ADD: HEX registers hold their previous values.
  - RESULT: HEX3 = seg(sum[4]); HEX2 = seg(sum[3:0]); HEX1 = seg(B); HEX0 = seg(A); no blinking.
- Latency:
  - SW change reaches HEX after 3 rising edges (2 sync + output register).
  - Key falling edge to state change: 3 edges.
  - ENTER in ENTER_B to result on HEX: ADD cycle plus output register.
- LEDR is combinational from the state register.
- Reset asserted mid-operation (including during ADD or the debounce window) takes effect immediately, with no clock needed. Outputs go to their reset values.

Test Plan (DEBOUNCE_CYCLES=4, BLINK_CYCLES=8):
1. Assert rst, apply no clock -> HEX0..HEX3 = 7F, LEDR = 0001. Deassert rst, SW=3, wait 3 clocks -> HEX0 = 30, HEX1..HEX3 = 7F.
2. SW=5, press ENTER; SW=7, press ENTER -> LEDR passes 0010, 0100, 1000; final HEX3=40, HEX2=46, HEX1=78, HEX0=12.
3. SW=F, ENTER, ENTER -> HEX3=79, HEX2=06, HEX1=0E, HEX0=0E. Another ENTER -> LEDR = 0001, HEX3..HEX1 = 7F.
4. Bounce: KEY_ENTER toggles 0/1/0 within 3 cycles of the first press -> only A latched, state ENTER_B. A second press after 4 cycles -> accepted.
5. In ENTER_B, assert KEY_ENTER and KEY_CLEAR in the same cycle -> state ENTER_A, B not latched. Later result with SW=0 for both operands: HEX3=40, HEX2=40.
6. In ENTER_A, hold SW=8 -> HEX0 alternates 00 / 7F every 8 cycles. Assert rst asynchronously during ADD -> all HEX = 7F and LEDR = 0001 before the next clk edge.
